serial_bcd_alu: RTL

//   Parametrised successor to the single-digit bit-serial adder. Adds or subtracts two LSB-first serial

---
 rtl/serial_alu_pkg.sv | 28 ++
 rtl/serial_timing_gen.sv | 76 +++++++
 rtl/serial_bcd_alu.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serial_alu_pkg.sv
// Shared constants and the per-digit BCD/binary add/subtract function for the serial BCD ALU.
package serial_alu_pkg;

  localparam logic [3:0] T1 = 4'b0001;
  localparam logic [3:0] T2 = 4'b0010;
  localparam logic [3:0] T3 = 4'b0100;
  localparam logic [3:0] T4 = 4'b1000;

  localparam logic [3:0] BCD_CORR_ADD = 4'd6;
  localparam logic [3:0] BCD_CORR_SUB = 4'd10;

  // Returns {carry/borrow out, result digit}.
  function automatic logic [4:0] digit_op(input logic [3:0] x, input logic [3:0] y,
                                          input logic c, input logic sub, input logic bin);
    logic [4:0] r;
    logic       adj;
    logic [3:0] corr;
    if (sub) r = {1'b0, x} - {1'b0, y} - {4'd0, c};
    else     r = {1'b0, x} + {1'b0, y} + {4'd0, c};
    // Bit 4 of the 5-bit result is the sign for subtract and the carry for add.
    adj  = sub ? r[4] : (r > 5'd9);
    corr = sub ? BCD_CORR_SUB : BCD_CORR_ADD;
    if (bin)      return r;
    else if (adj) return {1'b1, r[3:0] + corr};
    else          return {1'b0, r[3:0]};
  endfunction

endpackage

// File: rtl/serial_timing_gen.sv
// Bit/digit counters with SYNC restart, per-word field latch and field decode.
module serial_timing_gen
  import serial_alu_pkg::*;
#(
  parameter int unsigned DIGITS  = 14,
  parameter int unsigned FIELD_W = 4
) (
  input  logic               phi2,
  input  logic               reset,
  input  logic               sync,
  input  logic [FIELD_W-1:0] field_first,
  input  logic [FIELD_W-1:0] field_last,
  output logic               active,
  output logic [1:0]         bit_idx,
  output logic [FIELD_W-1:0] digit_idx,
  output logic [3:0]         t_state,
  output logic               in_field,
  output logic               is_first,
  output logic               empty_field,
  output logic               field_end
);

  localparam logic [FIELD_W-1:0] LastDigit = FIELD_W'(DIGITS - 1);

  logic [1:0]         bit_q, bit_d;
  logic [FIELD_W-1:0] dig_q, dig_d;
  logic               active_q;
  logic [FIELD_W-1:0] first_q, last_q, first_w, last_raw, last_w;

  always_comb begin
    active    = sync | active_q;
    bit_idx   = sync ? 2'd0 : bit_q;
    digit_idx = sync ? '0 : dig_q;
    first_w   = sync ? field_first : first_q;
    last_raw  = sync ? field_last : last_q;
    last_w    = (last_raw > LastDigit) ? LastDigit : last_raw;

    empty_field = first_w > last_w;
    in_field    = !empty_field && (digit_idx >= first_w) && (digit_idx <= last_w);
    is_first    = digit_idx == first_w;
    // An empty field still closes the word so CARRY can be cleared.
    field_end   = active && (bit_idx == 2'd3) &&
                  (empty_field ? (digit_idx == LastDigit) : (digit_idx == last_w));

    unique case (bit_idx)
      2'd0:    t_state = T1;
      2'd1:    t_state = T2;
      2'd2:    t_state = T3;
      default: t_state = T4;
    endcase

    bit_d = bit_idx;
    dig_d = digit_idx;
    if (active) begin
      bit_d = bit_idx + 2'd1;
      if (bit_idx == 2'd3) dig_d = (digit_idx == LastDigit) ? '0 : digit_idx + 1'b1;
    end
  end

  always_ff @(posedge phi2) begin
    if (reset) begin
      bit_q    <= 2'd0;
      dig_q    <= '0;
      active_q <= 1'b0;
      first_q  <= '0;
      last_q   <= '0;
    end else begin
      bit_q    <= bit_d;
      dig_q    <= dig_d;
      active_q <= active;
      first_q  <= first_w;
      last_q   <= last_raw;
    end
  end

endmodule

// File: rtl/serial_bcd_alu.sv
// Bit-serial BCD/binary add/subtract over a digit field with 4-cycle output latency.
// Optional zero detect enabled by defining SERIAL_ALU_ZERO_DETECT_EN.
module serial_bcd_alu
  import serial_alu_pkg::*;
#(
  parameter int unsigned DIGITS  = 14,
  parameter int unsigned FIELD_W = 4
) (
  input  logic               phi2,
  input  logic               reset,
  input  logic               sync,
  input  logic               x_in,
  input  logic               y_in,
  input  logic               c_in,
  input  logic               sub,
  input  logic               bin,
  input  logic [FIELD_W-1:0] field_first,
  input  logic [FIELD_W-1:0] field_last,
  output logic               sum_out,
  output logic               sum_valid,
  output logic [FIELD_W-1:0] sum_digit,
  output logic [3:0]         t_state,
`ifdef SERIAL_ALU_ZERO_DETECT_EN
  output logic               zero,
`endif
  output logic               carry
);

  logic               active, in_field, is_first, empty_field, field_end;
  logic [1:0]         bit_idx;
  logic [FIELD_W-1:0] digit_idx;

  serial_timing_gen #(
    .DIGITS (DIGITS),
    .FIELD_W(FIELD_W)
  ) u_timing (
    .phi2       (phi2),
    .reset      (reset),
    .sync       (sync),
    .field_first(field_first),
    .field_last (field_last),
    .active     (active),
    .bit_idx    (bit_idx),
    .digit_idx  (digit_idx),
    .t_state    (t_state),
    .in_field   (in_field),
    .is_first   (is_first),
    .empty_field(empty_field),
    .field_end  (field_end)
  );

  logic [2:0]         x_sr_q, y_sr_q;
  logic               sub_q, bin_q, chain_q, chain_d, carry_q, carry_d, valid_q;
  logic [3:0]         out_q, out_d, x_nib, y_nib;
  logic [FIELD_W-1:0] out_dig_q, out_dig_d;
  logic [4:0]         op;
  logic               sub_w, bin_w, cin, digit_done;

  always_comb begin
    sub_w      = sync ? sub : sub_q;
    bin_w      = sync ? bin : bin_q;
    x_nib      = {x_in, x_sr_q};
    y_nib      = {y_in, y_sr_q};
    cin        = is_first ? c_in : chain_q;
    op         = digit_op(x_nib, y_nib, cin, sub_w, bin_w);
    digit_done = active && (bit_idx == 2'd3);

    // The holding register doubles as the output shifter: load on T4, shift LSB first.
    out_d     = digit_done ? (in_field ? op[3:0] : x_nib) : {1'b0, out_q[3:1]};
    out_dig_d = digit_done ? digit_idx : out_dig_q;
    chain_d   = (digit_done && in_field) ? op[4] : chain_q;
    carry_d   = field_end ? (!empty_field && op[4]) : carry_q;
  end

  always_ff @(posedge phi2) begin
    if (reset) begin
      x_sr_q    <= '0;
      y_sr_q    <= '0;
      sub_q     <= 1'b0;
      bin_q     <= 1'b0;
      chain_q   <= 1'b0;
      out_q     <= '0;
      out_dig_q <= '0;
      valid_q   <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      x_sr_q    <= {x_in, x_sr_q[2:1]};
      y_sr_q    <= {y_in, y_sr_q[2:1]};
      sub_q     <= sub_w;
      bin_q     <= bin_w;
      chain_q   <= chain_d;
      out_q     <= out_d;
      out_dig_q <= out_dig_d;
      valid_q   <= valid_q | digit_done;
      carry_q   <= carry_d;
    end
  end

  assign sum_out   = out_q[0];
  assign sum_valid = valid_q;
  assign sum_digit = out_dig_q;
  assign carry     = carry_q;

`ifdef SERIAL_ALU_ZERO_DETECT_EN
  logic zacc_q, zacc_d, zero_q, zero_d, zfield;

  always_comb begin
    zfield = (is_first || zacc_q) && (op[3:0] == 4'd0);
    zacc_d = (digit_done && in_field) ? zfield : zacc_q;
    zero_d = field_end ? (empty_field || zfield) : zero_q;
  end

  always_ff @(posedge phi2) begin
    if (reset) begin
      zacc_q <= 1'b1;
      zero_q <= 1'b1;
    end else begin
      zacc_q <= zacc_d;
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`endif

endmodule
